// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the dinosaur game sequencer: state encodings,
// score/level widths and default timing constants.
// Optional build macro used by game_ctrl: HISCORE_EN.
package game_ctrl_pkg;

    localparam int GC_SCORE_W     = 14;
    localparam int GC_LEVEL_W     = 3;

    localparam int GC_DEB_CYCLES  = 16;
    localparam int GC_LEVEL_STEP  = 100;
    localparam int GC_MAX_LEVEL   = 7;
    localparam int GC_BASE_PERIOD = 16;
    localparam int GC_PERIOD_DEC  = 2;
    localparam int GC_DYING_TICKS = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, DEB_CYCLES consecutive-mismatch filter
// and a one-cycle pulse on each debounced released->pressed transition.
// Input is an active-low raw button.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int             CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;   // debounced raw level, 1 = released
    logic             armed_q;    // a released level has been seen since reset
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // the synchronized level is accepted on the last of DEB_CYCLES mismatches
    assign accept = (sync2_q != stable_q) && (cnt_q == CNT_LAST);

    // synchronizer resets to the pressed level so a button held through
    // reset release never shows a released level and cannot arm the edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // consecutive-mismatch counter; any matching cycle restarts the count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else if (sync2_q != stable_q) begin
            if (accept) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // press pulse only once the button has been seen released after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            armed_q <= armed_q | sync2_q;
            press_q <= accept & ~sync2_q & armed_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: central sequencer for the dinosaur game. Debounces the jump
// button, runs the IDLE/RUN/DYING/OVER state machine, gates the per-tick
// updaters and schedules enemy steps from the score-derived speed level.
// Optional build macro: HISCORE_EN adds a high-score register and port.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = GC_DEB_CYCLES,
    parameter int SCORE_W     = GC_SCORE_W,
    parameter int LEVEL_STEP  = GC_LEVEL_STEP,
    parameter int MAX_LEVEL   = GC_MAX_LEVEL,
    parameter int BASE_PERIOD = GC_BASE_PERIOD,
    parameter int PERIOD_DEC  = GC_PERIOD_DEC,
    parameter int DYING_TICKS = GC_DYING_TICKS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  jump_n,
    input  logic                  collide,
    input  logic [SCORE_W-1:0]    score,
    output logic [1:0]            state,
    output logic                  run_en,
    output logic                  step,
    output logic                  jump_pulse,
    output logic                  clear,
    output logic [GC_LEVEL_W-1:0] level,
    output logic                  blink
`ifdef HISCORE_EN
    ,
    output logic [SCORE_W-1:0]    hiscore
`endif
);

    localparam int                PER_W     = $clog2(BASE_PERIOD + 1);
    localparam int                DCNT_W    = $clog2(DYING_TICKS + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DYING_TICKS - 1);

    game_state_e           state_q;
    logic                  run_en_q;
    logic                  blink_q;
    logic [DCNT_W-1:0]     dcnt_q;
    logic [GC_LEVEL_W-1:0] level_q;
    logic [GC_LEVEL_W-1:0] level_d;
    logic [SCORE_W-1:0]    quot;
    logic [PER_W-1:0]      scnt_q;
    logic [PER_W-1:0]      period;
    logic                  press;
    logic                  new_game;
    logic                  step_hit;
    logic                  dying_done;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_jump_deb (
        .clk_i   (clock),
        .rst_ni  (reset),
        .btn_n_i (jump_n),
        .press_o (press)
    );

    // a press starts a game only from IDLE or OVER; in RUN it is just forwarded
    assign new_game   = press && (state_q == ST_IDLE || state_q == ST_OVER);
    assign dying_done = (state_q == ST_DYING) && tick && (dcnt_q == DCNT_LAST);

    // speed level from score, saturated at MAX_LEVEL
    always_comb begin
        quot = score / SCORE_W'(LEVEL_STEP);
        if (quot > SCORE_W'(MAX_LEVEL)) begin
            level_d = GC_LEVEL_W'(MAX_LEVEL);
        end else begin
            level_d = quot[GC_LEVEL_W-1:0];
        end
    end

    // enemy step period shrinks with level; >= lets a sudden period drop
    // below the running count fire on the very next tick
    always_comb begin
        period   = PER_W'(BASE_PERIOD - int'(level_q) * PERIOD_DEC);
        step_hit = (state_q == ST_RUN) && tick && ((scnt_q + PER_W'(1)) >= period);
    end

    // level register, forced to 0 during the new-game clear pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
        end else if (new_game) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // step tick counter, parked at 0 whenever the game is not running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scnt_q <= '0;
        end else if (state_q != ST_RUN) begin
            scnt_q <= '0;
        end else if (tick) begin
            scnt_q <= step_hit ? '0 : scnt_q + 1'b1;
        end
    end

    // game state machine with registered run_en / blink
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            run_en_q <= 1'b0;
            blink_q  <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (press) begin
                        state_q  <= ST_RUN;
                        run_en_q <= 1'b1;
                        blink_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // collision beats a simultaneous press
                    if (collide) begin
                        state_q  <= ST_DYING;
                        run_en_q <= 1'b0;
                        blink_q  <= 1'b0;
                        dcnt_q   <= '0;
                    end
                end
                ST_DYING: begin
                    if (tick) begin
                        if (dcnt_q == DCNT_LAST) begin
                            state_q <= ST_OVER;
                            blink_q <= 1'b1;
                            dcnt_q  <= '0;
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                            // flash flips after every 4th tick
                            if (dcnt_q[1:0] == 2'b11) begin
                                blink_q <= ~blink_q;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;

    // best score latched as a game ends; untouched by clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hiscore_q <= '0;
        end else if (dying_done && (score > hiscore_q)) begin
            hiscore_q <= score;
        end
    end

    assign hiscore = hiscore_q;
`endif

    assign state      = state_q;
    assign run_en     = run_en_q;
    assign step       = step_hit;
    assign jump_pulse = press;
    assign clear      = new_game;
    assign level      = level_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl. Step expectations come from a small
// scheduler model pushed into a queue as ticks are driven.
module tb_game_ctrl;
    import game_ctrl_pkg::*;

    localparam int M_BASE = 16;
    localparam int M_DEC  = 2;
    localparam int M_LSTEP = 100;
    localparam int M_MAXL = 7;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  tick = 1'b0;
    logic                  jump_n = 1'b1;
    logic                  collide = 1'b0;
    logic [GC_SCORE_W-1:0] score = '0;
    logic [1:0]            state;
    logic                  run_en;
    logic                  step;
    logic                  jump_pulse;
    logic                  clear;
    logic [GC_LEVEL_W-1:0] level;
    logic                  blink;
`ifdef HISCORE_EN
    logic [GC_SCORE_W-1:0] hiscore;
`endif

    int   checks = 0;
    int   errors = 0;
    int   mcnt = 0;
    int   mlevel = 0;
    logic exp_q[$];
    logic obs_q[$];
    int   lat_q[$];

    always #5 clock = ~clock;

    game_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .jump_n     (jump_n),
        .collide    (collide),
        .score      (score),
        .state      (state),
        .run_en     (run_en),
        .step       (step),
        .jump_pulse (jump_pulse),
        .clear      (clear),
        .level      (level),
        .blink      (blink)
`ifdef HISCORE_EN
        ,
        .hiscore    (hiscore)
`endif
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // drive n cycles, tick on every 'every'-th; model expected step per tick
    task automatic run_ticks(input int n, input int every);
        for (int i = 0; i < n; i++) begin
            logic t;
            logic e;
            t = ((i % every) == (every - 1));
            tick = t;
            e = t && ((mcnt + 1) >= (M_BASE - mlevel * M_DEC));
            if (t) exp_q.push_back(e);
            #1;
            if (t) begin
                obs_q.push_back(step);
                mcnt = e ? 0 : mcnt + 1;
            end
            mlevel = ((int'(score) / M_LSTEP) > M_MAXL) ? M_MAXL : int'(score) / M_LSTEP;
            @(negedge clock);
            tick = 1'b0;
        end
    endtask

    // press and wait (bounded) for jump_pulse; lat = -1 on timeout
    task automatic press_wait(output int lat);
        lat = -1;
        jump_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (jump_pulse === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++;
        if ({run_en, step, jump_pulse, clear, blink} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {run_en, step, jump_pulse, clear, blink});
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        reset = 1'b1;
        cyc(4);
    endtask

    task automatic test_glitch();
        int np = 0;
        repeat (5) begin
            jump_n = 1'b0;
            for (int i = 0; i < 10; i++) begin @(negedge clock); if (jump_pulse === 1'b1) np++; end
            jump_n = 1'b1;
            for (int i = 0; i < 10; i++) begin @(negedge clock); if (jump_pulse === 1'b1) np++; end
        end
        for (int i = 0; i < 20; i++) begin @(negedge clock); if (jump_pulse === 1'b1) np++; end
        checks++; if (np != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", np); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL glitch_state got %0d want 0", state); end
    endtask

    task automatic test_press();
        int lat;
        int np = 0;
        int want;
        lat_q.push_back(18);
        press_wait(lat);
        want = lat_q.pop_front();
        checks++; if (lat != want) begin errors++; $display("FAIL press_latency got %0d want %0d", lat, want); end
        checks++; if (clear !== 1'b1) begin errors++; $display("FAIL press_clear got %b want 1", clear); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL press_state_same got %0d want 0", state); end
        @(negedge clock);
        checks++; if (state !== ST_RUN) begin errors++; $display("FAIL press_state_next got %0d want 1", state); end
        checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL press_run_en got %b want 1", run_en); end
        checks++;
        if ({jump_pulse, clear} !== 2'b00) begin
            errors++; $display("FAIL press_one_cycle got %b want 00", {jump_pulse, clear});
        end
        @(negedge clock);
        jump_n = 1'b1;
        for (int i = 0; i < 25; i++) begin @(negedge clock); if (jump_pulse === 1'b1) np++; end
        checks++; if (np != 0) begin errors++; $display("FAIL release_pulse got %0d want 0", np); end
    endtask

    task automatic test_steps();
        int nst;
        mcnt = 0; mlevel = 0; score = '0;
        // level 0: 64 ticks, one step per 16
        run_ticks(128, 2);
        nst = 0;
        while (exp_q.size() > 0) begin
            logic e; logic o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL step_l0 got %b want %b", o, e); end
            if (o === 1'b1) nst++;
        end
        checks++; if (nst != 4) begin errors++; $display("FAIL step_l0_count got %0d want 4", nst); end
        // level 3: period 10
        score = 14'd350;
        run_ticks(1, 2);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL level_350 got %0d want 3", level); end
        run_ticks(80, 2);
        nst = 0;
        while (exp_q.size() > 0) begin
            logic e; logic o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL step_l3 got %b want %b", o, e); end
            if (o === 1'b1) nst++;
        end
        checks++; if (nst != 4) begin errors++; $display("FAIL step_l3_count got %0d want 4", nst); end
        // period collapses below the running count: fires on the next tick
        score = '0;
        run_ticks(1, 2);
        run_ticks(24, 2);
        score = 14'd700;
        run_ticks(1, 2);
        checks++; if (level !== 3'd7) begin errors++; $display("FAIL level_700 got %0d want 7", level); end
        run_ticks(2, 1);
        nst = 0;
        while (exp_q.size() > 0) begin
            logic e; logic o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL step_drop got %b want %b", o, e); end
            if (o === 1'b1) nst++;
        end
        checks++; if (nst != 1) begin errors++; $display("FAIL step_drop_count got %0d want 1", nst); end
        score = '0;
        run_ticks(1, 2);
    endtask

    task automatic test_collide_jump();
        int lat;
        press_wait(lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL run_press_timeout got %0d want >0", lat); end
        collide = 1'b1;
        checks++; if (clear !== 1'b0) begin errors++; $display("FAIL run_press_clear got %b want 0", clear); end
        @(negedge clock);
        collide = 1'b0;
        jump_n = 1'b1;
        checks++; if (state !== ST_DYING) begin errors++; $display("FAIL collide_state got %0d want 2", state); end
        checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL collide_run_en got %b want 0", run_en); end
        score = 14'd420;
        tick = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clock);
            if (n < 24) begin
                checks++;
                if (state !== ST_DYING || blink !== 1'(((n / 4) % 2))) begin
                    errors++; $display("FAIL dying_tick%0d got st=%0d blink=%b want st=2 blink=%0d", n, state, blink, (n / 4) % 2);
                end
            end
        end
        tick = 1'b0;
        checks++; if (state !== ST_OVER) begin errors++; $display("FAIL over_state got %0d want 3", state); end
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL over_blink got %b want 1", blink); end
`ifdef HISCORE_EN
        checks++; if (hiscore !== 14'd420) begin errors++; $display("FAIL hiscore_first got %0d want 420", hiscore); end
`endif
    endtask

    task automatic test_restart();
        int lat;
        int idx;
        int first;
        press_wait(lat);
        checks++; if (clear !== 1'b1) begin errors++; $display("FAIL restart_clear got %b want 1", clear); end
        checks++; if (state !== ST_OVER) begin errors++; $display("FAIL restart_state_same got %0d want 3", state); end
        @(negedge clock);
        checks++; if (state !== ST_RUN) begin errors++; $display("FAIL restart_state got %0d want 1", state); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL restart_level got %0d want 0", level); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL restart_blink got %b want 0", blink); end
        score = '0;
        jump_n = 1'b1;
        mcnt = 0; mlevel = 0;
        run_ticks(1, 2);
        run_ticks(32, 2);
        idx = 0; first = -1;
        while (exp_q.size() > 0) begin
            logic e; logic o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            idx++;
            checks++; if (o !== e) begin errors++; $display("FAIL restart_step got %b want %b", o, e); end
            if (o === 1'b1 && first < 0) first = idx;
        end
        checks++; if (first != 16) begin errors++; $display("FAIL restart_first_step got %0d want 16", first); end
    endtask

`ifdef HISCORE_EN
    task automatic test_hiscore();
        int lat;
        score = 14'd300;
        collide = 1'b1;
        @(negedge clock);
        collide = 1'b0;
        tick = 1'b1;
        cyc(24);
        tick = 1'b0;
        checks++; if (state !== ST_OVER) begin errors++; $display("FAIL hs_over got %0d want 3", state); end
        checks++; if (hiscore !== 14'd420) begin errors++; $display("FAIL hiscore_keep got %0d want 420", hiscore); end
        press_wait(lat);
        @(negedge clock);
        jump_n = 1'b1;
        score = '0;
        cyc(24);
        checks++; if (hiscore !== 14'd420) begin errors++; $display("FAIL hiscore_clear got %0d want 420", hiscore); end
    endtask
`endif

    task automatic test_reset_mid();
        int np = 0;
        int lat;
        score = 14'd350;
        collide = 1'b1;
        @(negedge clock);
        collide = 1'b0;
        tick = 1'b1;
        cyc(5);
        tick = 1'b0;
        checks++;
        if (state !== ST_DYING || blink !== 1'b1 || level !== 3'd3) begin
            errors++; $display("FAIL pre_reset got st=%0d blink=%b lvl=%0d want st=2 blink=1 lvl=3", state, blink, level);
        end
        jump_n = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state got %0d want 0", state); end
        checks++;
        if ({run_en, step, jump_pulse, clear, blink} !== 5'b0 || level !== 3'd0) begin
            errors++; $display("FAIL async_outs got %b lvl=%0d want 00000 lvl=0", {run_en, step, jump_pulse, clear, blink}, level);
        end
        score = '0;
        cyc(3);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin @(negedge clock); if (jump_pulse === 1'b1) np++; end
        checks++; if (np != 0) begin errors++; $display("FAIL held_pulse got %0d want 0", np); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL held_state got %0d want 0", state); end
        jump_n = 1'b1;
        cyc(25);
        press_wait(lat);
        checks++; if (lat != 18) begin errors++; $display("FAIL repress_latency got %0d want 18", lat); end
        @(negedge clock);
        checks++; if (state !== ST_RUN) begin errors++; $display("FAIL repress_state got %0d want 1", state); end
        jump_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_steps();
        test_collide_jump();
        test_restart();
`ifdef HISCORE_EN
        test_hiscore();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
